// File: rtl/cpu_seq_pkg.sv
// Shared types and encodings for the cpu_sequencer control FSM and its decoder.
package cpu_seq_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned XFER_W  = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    WB    = 2'd3
  } state_t;

  // Opcode prefixes, grouped by length (matched longest first)
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B     = 6'b000101;

  localparam logic [ALUOP_W-1:0] ALU_PASS_B = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD    = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_SUB    = 3'b011;

  localparam logic [3:0] COND_LT = 4'b1011;

  localparam logic [XFER_W-1:0] XFER_DWORD = 4'd8;
  localparam logic [XFER_W-1:0] XFER_BYTE  = 4'd1;

  typedef struct packed {
    logic                reg2loc;
    logic                alu_src;
    logic                imm12;
    logic                movk;
    logic                mem_to_reg;
    logic [ALUOP_W-1:0]  alu_op;
    logic [XFER_W-1:0]   xfer_size;
    logic                byte_loader;
    logic                set_flags;
    logic                is_load;
    logic                is_store;
    logic                is_alu;
    logic                is_b;
    logic                is_cbz;
    logic                is_blt;
    logic                illegal;
  } ctrl_t;

  // Sign-extended, word-scaled branch offset (imm26 for B, imm19 otherwise)
  function automatic logic [XLEN-1:0] br_offset(input logic [25:0] imm, input logic is_b);
    logic [XLEN-1:0] off;
    if (is_b) off = {{36{imm[25]}}, imm, 2'b00};
    else      off = {{43{imm[23]}}, imm[23:5], 2'b00};
    return off;
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational opcode-to-control decode; MOVZ/MOVK decode only with CPU_SEQ_MOVE_EN.
module cpu_seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [10:0] op_i,
  input  logic [3:0]  cond_i,
  output ctrl_t       ctrl_c
);

  always_comb begin
    ctrl_c         = '0;
    ctrl_c.illegal = 1'b1;
    if (op_i == OP_LDUR || op_i == OP_LDURB) begin
      ctrl_c.illegal     = 1'b0;
      ctrl_c.is_load     = 1'b1;
      ctrl_c.alu_src     = 1'b1;
      ctrl_c.alu_op      = ALU_ADD;
      ctrl_c.mem_to_reg  = 1'b1;
      ctrl_c.byte_loader = (op_i == OP_LDUR);
      ctrl_c.xfer_size   = (op_i == OP_LDUR) ? XFER_DWORD : XFER_BYTE;
    end else if (op_i == OP_STUR || op_i == OP_STURB) begin
      ctrl_c.illegal     = 1'b0;
      ctrl_c.is_store    = 1'b1;
      ctrl_c.alu_src     = 1'b1;
      ctrl_c.alu_op      = ALU_ADD;
      ctrl_c.byte_loader = (op_i == OP_STUR);
      ctrl_c.xfer_size   = (op_i == OP_STUR) ? XFER_DWORD : XFER_BYTE;
    end else if (op_i == OP_ADDS || op_i == OP_SUBS) begin
      ctrl_c.illegal   = 1'b0;
      ctrl_c.is_alu    = 1'b1;
      ctrl_c.reg2loc   = 1'b1;
      ctrl_c.set_flags = 1'b1;
      ctrl_c.alu_op    = (op_i == OP_ADDS) ? ALU_ADD : ALU_SUB;
    end else if (op_i[10:1] == OP_ADDI) begin
      ctrl_c.illegal = 1'b0;
      ctrl_c.is_alu  = 1'b1;
      ctrl_c.imm12   = 1'b1;
      ctrl_c.alu_op  = ALU_ADD;
`ifdef CPU_SEQ_MOVE_EN
    end else if (op_i[10:2] == OP_MOVZ) begin
      ctrl_c.illegal = 1'b0;
      ctrl_c.is_alu  = 1'b1;
      ctrl_c.imm12   = 1'b1;
      ctrl_c.alu_src = 1'b1;
      ctrl_c.alu_op  = ALU_PASS_B;
    end else if (op_i[10:2] == OP_MOVK) begin
      ctrl_c.illegal = 1'b0;
      ctrl_c.is_alu  = 1'b1;
      ctrl_c.movk    = 1'b1;
      ctrl_c.alu_op  = ALU_PASS_B;
`endif
    end else if (op_i[10:3] == OP_CBZ) begin
      ctrl_c.illegal = 1'b0;
      ctrl_c.is_cbz  = 1'b1;
    end else if (op_i[10:3] == OP_BCOND && cond_i == COND_LT) begin
      ctrl_c.illegal = 1'b0;
      ctrl_c.is_blt  = 1'b1;
    end else if (op_i[10:5] == OP_B) begin
      ctrl_c.illegal = 1'b0;
      ctrl_c.is_b    = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with pc and branch resolution.
// Optional MOVZ/MOVK support is selected by CPU_SEQ_MOVE_EN (see cpu_seq_decode).
module cpu_sequencer
  import cpu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [ILEN-1:0]     instr_in,
  output logic [XLEN-1:0]     pc,
  input  logic                zeroCurr,
  input  logic                negativeAlu,
  input  logic                overflowAlu,
  output logic [ILEN-1:0]     Instruction,
  output logic                Reg2Loc,
  output logic                ALUSrc,
  output logic                imm12Cntrl,
  output logic                movKCntrl,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                write_enable,
  output logic                read_enable,
  output logic                byteLoader,
  output logic                flagSignal,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic [XFER_W-1:0]   xfer_size,
  output logic                busy,
  output logic                illegal
);

  state_t              state_q, state_d;
  logic [ILEN-1:0]     instr_q, instr_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                illegal_q, illegal_d;
  logic                imem_req_q, imem_req_d;
  logic                busy_q, busy_d;
  logic                reg2loc_q, reg2loc_d;
  logic                alu_src_q, alu_src_d;
  logic                imm12_q, imm12_d;
  logic                movk_q, movk_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic                reg_write_q, reg_write_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                byte_loader_q, byte_loader_d;
  logic                flag_q, flag_d;
  logic [ALUOP_W-1:0]  alu_op_q, alu_op_d;
  logic [XFER_W-1:0]   xfer_q, xfer_d;

  ctrl_t               dec;
  logic                taken;
  logic                active;

  // Decode follows the instruction about to be held, so controls register in step with state
  cpu_seq_decode u_decode (
    .op_i   (instr_d[31:21]),
    .cond_i (instr_d[3:0]),
    .ctrl_c (dec)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    taken     = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_req_q && imem_ack) begin
          instr_d = instr_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        taken = dec.is_b | (dec.is_cbz & zeroCurr) | (dec.is_blt & (negativeAlu ^ overflowAlu));
        if (dec.illegal)                     state_d = FETCH;
        else if (dec.is_load | dec.is_store) state_d = MEM;
        else if (dec.is_alu)                 state_d = WB;
        else                                 state_d = FETCH;
      end
      MEM:     state_d = dec.is_load ? WB : FETCH;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase

    // pc moves once per instruction, on the edge that returns to FETCH
    if (state_q != FETCH && state_d == FETCH) begin
      pc_d = taken ? pc_q + br_offset(instr_q[25:0], dec.is_b) : pc_q + 64'd4;
    end

    active        = (state_d != FETCH);
    illegal_d     = illegal_q | ((state_d == EXEC) & dec.illegal);
    imem_req_d    = (state_d == FETCH) & run;
    busy_d        = active;
    reg2loc_d     = active & dec.reg2loc;
    alu_src_d     = active & dec.alu_src;
    imm12_d       = active & dec.imm12;
    movk_d        = active & dec.movk;
    mem_to_reg_d  = active & dec.mem_to_reg;
    byte_loader_d = active & dec.byte_loader;
    alu_op_d      = active ? dec.alu_op : ALUOP_W'(0);
    xfer_d        = active ? dec.xfer_size : XFER_W'(0);
    flag_d        = (state_d == EXEC) & dec.set_flags;
    wr_en_d       = (state_d == MEM) & dec.is_store;
    rd_en_d       = (state_d == MEM) & dec.is_load;
    reg_write_d   = (state_d == WB);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= FETCH;
      instr_q       <= '0;
      pc_q          <= '0;
      illegal_q     <= 1'b0;
      imem_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      reg2loc_q     <= 1'b0;
      alu_src_q     <= 1'b0;
      imm12_q       <= 1'b0;
      movk_q        <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      byte_loader_q <= 1'b0;
      flag_q        <= 1'b0;
      alu_op_q      <= '0;
      xfer_q        <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      illegal_q     <= illegal_d;
      imem_req_q    <= imem_req_d;
      busy_q        <= busy_d;
      reg2loc_q     <= reg2loc_d;
      alu_src_q     <= alu_src_d;
      imm12_q       <= imm12_d;
      movk_q        <= movk_d;
      mem_to_reg_q  <= mem_to_reg_d;
      reg_write_q   <= reg_write_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      byte_loader_q <= byte_loader_d;
      flag_q        <= flag_d;
      alu_op_q      <= alu_op_d;
      xfer_q        <= xfer_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign pc           = pc_q;
  assign Instruction  = instr_q;
  assign Reg2Loc      = reg2loc_q;
  assign ALUSrc       = alu_src_q;
  assign imm12Cntrl   = imm12_q;
  assign movKCntrl    = movk_q;
  assign MemtoReg     = mem_to_reg_q;
  assign RegWrite     = reg_write_q;
  assign write_enable = wr_en_q;
  assign read_enable  = rd_en_q;
  assign byteLoader   = byte_loader_q;
  assign flagSignal   = flag_q;
  assign ALUop        = alu_op_q;
  assign xfer_size    = xfer_q;
  assign busy         = busy_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer; MOVK expectations follow CPU_SEQ_MOVE_EN.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, imem_ack;
  logic [31:0] instr_in;
  logic        zeroCurr, negativeAlu, overflowAlu;
  logic        imem_req;
  logic [63:0] pc;
  logic [31:0] Instruction;
  logic        Reg2Loc, ALUSrc, imm12Cntrl, movKCntrl, MemtoReg, RegWrite;
  logic        write_enable, read_enable, byteLoader, flagSignal, busy, illegal;
  logic [2:0]  ALUop;
  logic [3:0]  xfer_size;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr_in(instr_in), .pc(pc), .zeroCurr(zeroCurr), .negativeAlu(negativeAlu),
    .overflowAlu(overflowAlu), .Instruction(Instruction), .Reg2Loc(Reg2Loc),
    .ALUSrc(ALUSrc), .imm12Cntrl(imm12Cntrl), .movKCntrl(movKCntrl), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .write_enable(write_enable), .read_enable(read_enable),
    .byteLoader(byteLoader), .flagSignal(flagSignal), .ALUop(ALUop), .xfer_size(xfer_size),
    .busy(busy), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a negedge; returns sampled in EXEC
  task automatic fetch(input logic [31:0] ins);
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    check("fetch_req", 64'(imem_req), 64'd1);
    instr_in = ins;
    imem_ack = 1'b1;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; imem_ack = 1'b0; instr_in = '0;
    zeroCurr = 1'b0; negativeAlu = 1'b0; overflowAlu = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc, 64'd0);
    check("rst_instr", 64'(Instruction), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_req", 64'(imem_req), 64'd0);
    reset = 1'b1;

    // ADDI X1,X0,#1
    fetch(32'h9100_0401);
    check("addi_instr", 64'(Instruction), 64'h9100_0401);
    check("addi_busy", 64'(busy), 64'd1);
    check("addi_imm12", 64'(imm12Cntrl), 64'd1);
    check("addi_alusrc", 64'(ALUSrc), 64'd0);
    check("addi_aluop", 64'(ALUop), 64'd2);
    check("addi_exec_rw", 64'(RegWrite), 64'd0);
    check("addi_flag", 64'(flagSignal), 64'd0);
    cyc();
    check("addi_wb_rw", 64'(RegWrite), 64'd1);
    check("addi_wb_pc", pc, 64'd0);
    cyc();
    check("addi_done_rw", 64'(RegWrite), 64'd0);
    check("addi_pc", pc, 64'd4);
    check("addi_busy_done", 64'(busy), 64'd0);

    // STUR X1,[X2]
    fetch(32'hF800_0041);
    check("stur_alusrc", 64'(ALUSrc), 64'd1);
    check("stur_exec_we", 64'(write_enable), 64'd0);
    cyc();
    check("stur_we", 64'(write_enable), 64'd1);
    check("stur_xfer", 64'(xfer_size), 64'd8);
    check("stur_bytel", 64'(byteLoader), 64'd1);
    check("stur_reg2loc", 64'(Reg2Loc), 64'd0);
    cyc();
    check("stur_we_off", 64'(write_enable), 64'd0);
    check("stur_rw", 64'(RegWrite), 64'd0);
    check("stur_pc", pc, 64'd8);

    // LDURB X1,[X2]; run dropped mid-instruction must not abort it
    fetch(32'h3840_0041);
    run = 1'b0;
    cyc();
    check("ldurb_re", 64'(read_enable), 64'd1);
    check("ldurb_xfer", 64'(xfer_size), 64'd1);
    check("ldurb_bytel", 64'(byteLoader), 64'd0);
    check("ldurb_we", 64'(write_enable), 64'd0);
    cyc();
    check("ldurb_re_off", 64'(read_enable), 64'd0);
    check("ldurb_wb_rw", 64'(RegWrite), 64'd1);
    check("ldurb_m2r", 64'(MemtoReg), 64'd1);
    cyc();
    check("ldurb_pc", pc, 64'hC);
    check("run0_req", 64'(imem_req), 64'd0);
    cyc();
    check("run0_req_hold", 64'(imem_req), 64'd0);
    check("run0_busy", 64'(busy), 64'd0);
    run = 1'b1;
    cyc();

    // imem_ack withheld for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 64'(imem_req), 64'd1);
      check("stall_pc", pc, 64'hC);
      check("stall_busy", 64'(busy), 64'd0);
      cyc();
    end

    // B +61 words: 0xC -> 0x100
    fetch(32'h1400_003D);
    check("b_rw", 64'(RegWrite), 64'd0);
    cyc();
    check("b_pc", pc, 64'h100);

    // CBZ imm19=-2 taken: 0x100 -> 0xF8
    zeroCurr = 1'b1;
    fetch(32'hB4FF_FFC0);
    check("cbz_reg2loc", 64'(Reg2Loc), 64'd0);
    check("cbz_alusrc", 64'(ALUSrc), 64'd0);
    check("cbz_aluop", 64'(ALUop), 64'd0);
    cyc();
    check("cbz_t_pc", pc, 64'hF8);
    check("cbz_t_rw", 64'(RegWrite), 64'd0);
    fetch(32'h1400_0002);
    cyc();
    check("b2_pc", pc, 64'h100);
    zeroCurr = 1'b0;
    fetch(32'hB4FF_FFC0);
    cyc();
    check("cbz_nt_pc", pc, 64'h104);
    check("cbz_nt_rw", 64'(RegWrite), 64'd0);

    // B -58 words: 0x104 -> 0x1C
    fetch(32'h17FF_FFC6);
    cyc();
    check("bneg_pc", pc, 64'h1C);

    // SUBS X3,X1,X2 at 0x1C, negative result without overflow
    negativeAlu = 1'b1; overflowAlu = 1'b0;
    fetch(32'hEB02_0023);
    check("subs_flag", 64'(flagSignal), 64'd1);
    check("subs_reg2loc", 64'(Reg2Loc), 64'd1);
    check("subs_aluop", 64'(ALUop), 64'd3);
    cyc();
    check("subs_wb_flag", 64'(flagSignal), 64'd0);
    check("subs_wb_rw", 64'(RegWrite), 64'd1);
    cyc();
    check("subs_pc", pc, 64'h20);

    // B.LT +3 at 0x20 taken, then not taken at 0x2C
    fetch(32'h5400_006B);
    check("blt_flag", 64'(flagSignal), 64'd0);
    cyc();
    check("blt_t_pc", pc, 64'h2C);
    overflowAlu = 1'b1;
    fetch(32'h5400_006B);
    cyc();
    check("blt_nt_pc", pc, 64'h30);

    // Undecoded opcode
    fetch(32'hFFFF_FFFF);
    check("ill_set", 64'(illegal), 64'd1);
    check("ill_flag", 64'(flagSignal), 64'd0);
    cyc();
    check("ill_rw", 64'(RegWrite), 64'd0);
    check("ill_we", 64'(write_enable), 64'd0);
    check("ill_pc", pc, 64'h34);
    fetch(32'h9100_0401);
    cyc(); cyc();
    check("ill_sticky", 64'(illegal), 64'd1);
    check("ill_next_pc", pc, 64'h38);

    // Reset while a store sits in EXEC, with an ack pending
    fetch(32'hF800_0041);
    reset = 1'b0;
    imem_ack = 1'b1;
    instr_in = 32'h9100_0401;
    cyc();
    check("rstmid_we", 64'(write_enable), 64'd0);
    check("rstmid_pc", pc, 64'd0);
    check("rstmid_instr", 64'(Instruction), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_ill", 64'(illegal), 64'd0);
    check("rstmid_alusrc", 64'(ALUSrc), 64'd0);
    imem_ack = 1'b0;
    reset = 1'b1;
    cyc();
    check("rstmid_we2", 64'(write_enable), 64'd0);

    // MOVK X0,#1
    fetch(32'hF280_0020);
`ifdef CPU_SEQ_MOVE_EN
    check("movk_exec", 64'(movKCntrl), 64'd1);
    check("movk_aluop", 64'(ALUop), 64'd0);
    check("movk_ill", 64'(illegal), 64'd0);
    cyc();
    check("movk_wb", 64'(movKCntrl), 64'd1);
    check("movk_wb_rw", 64'(RegWrite), 64'd1);
    cyc();
`else
    check("movk_ill", 64'(illegal), 64'd1);
    check("movk_exec", 64'(movKCntrl), 64'd0);
    cyc();
    check("movk_rw", 64'(RegWrite), 64'd0);
    check("movk_wb", 64'(movKCntrl), 64'd0);
`endif
    check("movk_pc", pc, 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
